// File: rtl/muldiv_unit.sv
// muldiv_unit: sequential RV32M-style multiply/divide unit.
// Holds one operation at a time and uses valid/ready handshakes on both sides.
// Iterative ops run one bit per cycle on operand magnitudes.
// The result sign is applied once, when the final value is captured.
module muldiv_unit #(
  parameter int XLEN     = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] y,
  output logic            busy
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN-1:0] ZERO_X = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONE_X  = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] ONES_X = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_X  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   ONE_C  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   XLEN_C = CW'(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   y_q, y_d;

  logic              sa_s, sb_s, a_neg_s, b_neg_s, neg_in_s, ovf_s;
  logic [XLEN-1:0]   a_mag_s, b_mag_s;
  logic [2*XLEN-1:0] fast_prod_s;
  logic [XLEN:0]     shifted_s, diff_s, sum_s;
  logic [XLEN-1:0]   iter_hi_s, iter_lo_s;

  // Magnitude of a value that is negative only when treated as signed.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
    logic [XLEN-1:0] r;
    if (sgn && v[XLEN-1]) begin
      r = ~v + ONE_X;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Apply the deferred sign to the raw magnitude result and pick the selected half.
  function automatic logic [XLEN-1:0] fixup(input logic [2:0] o, input logic neg,
                                            input logic [XLEN-1:0] hi, input logic [XLEN-1:0] lo);
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   r;
    if (neg) begin
      p = ~{hi, lo} + {{(2*XLEN-1){1'b0}}, 1'b1};
    end else begin
      p = {hi, lo};
    end
    case (o)
      OP_MUL:                       r = p[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: r = p[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              r = neg ? (~lo + ONE_X) : lo;
      OP_REM, OP_REMU:              r = neg ? (~hi + ONE_X) : hi;
      default:                      r = lo;
    endcase
    return r;
  endfunction

  // Operand signedness, magnitudes and result sign for an incoming request.
  always_comb begin
    sa_s = 1'b0;
    sb_s = 1'b0;
    case (op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        sa_s = 1'b1;
        sb_s = 1'b1;
      end
      OP_MULHSU: begin
        sa_s = 1'b1;
        sb_s = 1'b0;
      end
      default: begin
        sa_s = 1'b0;
        sb_s = 1'b0;
      end
    endcase
    a_neg_s     = sa_s & a[XLEN-1];
    b_neg_s     = sb_s & b[XLEN-1];
    neg_in_s    = (op == OP_REM) ? a_neg_s : (a_neg_s ^ b_neg_s);
    a_mag_s     = mag(a, sa_s);
    b_mag_s     = mag(b, sb_s);
    ovf_s       = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_X) && (b == ONES_X);
    fast_prod_s = {ZERO_X, a_mag_s} * {ZERO_X, b_mag_s};
  end

  // One shift-add multiply step or one restoring-divide step on the held operands.
  always_comb begin
    shifted_s = {hi_q, lo_q[XLEN-1]};
    diff_s    = shifted_s - {1'b0, mcand_q};
    sum_s     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
    if (op_q[2]) begin
      if (!diff_s[XLEN]) begin
        iter_hi_s = diff_s[XLEN-1:0];
        iter_lo_s = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        iter_hi_s = shifted_s[XLEN-1:0];
        iter_lo_s = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      iter_hi_s = sum_s[XLEN:1];
      iter_lo_s = {sum_s[0], lo_q[XLEN-1:1]};
    end
  end

  // Next-state logic for the IDLE/BUSY/DONE sequencer and its datapath registers.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    y_d     = y_q;
    case (state_q)
      S_IDLE: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (in_valid) begin
          op_d    = op;
          neg_d   = neg_in_s;
          hi_d    = ZERO_X;
          lo_d    = a_mag_s;
          mcand_d = b_mag_s;
          if (op[2] && (b == ZERO_X)) begin
            state_d = S_DONE;
            y_d     = op[1] ? a : ONES_X;
          end else if (ovf_s) begin
            state_d = S_DONE;
            y_d     = op[1] ? ZERO_X : a;
          end else if (!op[2] && (FAST_MUL == 1'b1)) begin
            state_d = S_DONE;
            y_d     = fixup(op, neg_in_s, fast_prod_s[2*XLEN-1:XLEN], fast_prod_s[XLEN-1:0]);
          end else begin
            state_d = S_BUSY;
            cnt_d   = XLEN_C;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          hi_d  = iter_hi_s;
          lo_d  = iter_lo_s;
          cnt_d = cnt_q - ONE_C;
          if (cnt_q == ONE_C) begin
            state_d = S_DONE;
            y_d     = fixup(op_q, neg_q, iter_hi_s, iter_lo_s);
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_DONE: begin
        if (flush || out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 3'b000;
      neg_q   <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      hi_q    <= ZERO_X;
      lo_q    <= ZERO_X;
      mcand_q <= ZERO_X;
      y_q     <= ZERO_X;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      y_q     <= y_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign y         = y_q;

endmodule
